// File: rtl/mem_arbiter.sv
// Arbitrates the single synchronous memory port between the CPU and the host loader.
// Optional: define MEM_ARBITER_ROM_WP_EN to block CPU writes at or above ROM_BASE (reported on cERR).
module mem_arbiter #(
    parameter int            AW         = 16,
    parameter int            DW         = 8,
    parameter int            CPU_WEIGHT = 4,
    parameter int            LDR_BURST  = 16,
    parameter logic [AW-1:0] ROM_BASE   = 16'hF000
) (
    input  logic          CLK,
    input  logic          R_N,
    input  logic          cREQ,
    input  logic          cWE,
    input  logic [AW-1:0] cADDR,
    input  logic [DW-1:0] cDIN,
    output logic [DW-1:0] cDOUT,
    output logic          cRDY,
    output logic          CPU_HOLD,
    input  logic          lREQ,
    input  logic          lWE,
    input  logic [AW-1:0] lADDR,
    input  logic [DW-1:0] lDIN,
    output logic [DW-1:0] lDOUT,
    output logic          lACK,
    output logic          lGNT,
    output logic [AW-1:0] mADDR,
    output logic [DW-1:0] mDIN,
    output logic          mWE,
    output logic          mOEN,
    input  logic [DW-1:0] mDOUT,
    output logic          cERR
);

`ifdef MEM_ARBITER_ROM_WP_EN
    localparam logic WP_EN = 1'b1;
`else
    localparam logic WP_EN = 1'b0;
`endif

    localparam logic [3:0] CW = 4'(CPU_WEIGHT);
    localparam logic [7:0] LB = 8'(LDR_BURST);

    // state  | meaning
    // IDLE   | no grant last cycle
    // CPU    | last grant went to the CPU
    // LDR    | last grant went to the loader
    typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_LDR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cpu_cnt_q, cpu_cnt_d;
    logic [7:0]    ldr_cnt_q, ldr_cnt_d;
    logic          c_gnt, l_gnt, ldr_force;
    logic          creq, lreq, c_prot;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q, cdout_q, ldout_q;
    logic          c_own_q, l_own_q, rd_q, err_q;

    // Requests are masked while in reset so the memory port is idle immediately.
    assign creq   = cREQ & R_N;
    assign lreq   = lREQ & R_N;
    assign c_prot = WP_EN & cWE & (cADDR >= ROM_BASE);

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state_q   <= ST_IDLE;
            cpu_cnt_q <= '0;
            ldr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_cnt_q <= cpu_cnt_d;
            ldr_cnt_q <= ldr_cnt_d;
        end
    end

    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        ldr_force = 1'b0;
        if (creq && lreq) begin
            if (state_q == ST_LDR) begin
                if (ldr_cnt_q < LB) l_gnt = 1'b1;
                else                c_gnt = 1'b1;
            end else if (cpu_cnt_q == CW) begin
                l_gnt     = 1'b1;
                ldr_force = 1'b1;
            end else begin
                c_gnt = 1'b1;
            end
        end else begin
            c_gnt = creq;
            l_gnt = lreq;
        end

        state_d = c_gnt ? ST_CPU : (l_gnt ? ST_LDR : ST_IDLE);

        cpu_cnt_d = cpu_cnt_q;
        if (l_gnt || !lreq)             cpu_cnt_d = '0;
        else if (c_gnt && cpu_cnt_q != CW) cpu_cnt_d = cpu_cnt_q + 4'd1;

        // A forced fairness slot preloads the burst limit so the CPU regains the bus next cycle.
        ldr_cnt_d = ldr_cnt_q;
        if (c_gnt || !creq)                ldr_cnt_d = '0;
        else if (ldr_force)                ldr_cnt_d = LB;
        else if (l_gnt && ldr_cnt_q != LB) ldr_cnt_d = ldr_cnt_q + 8'd1;
    end

    always_comb begin
        mADDR    = addr_q;
        mDIN     = din_q;
        mWE      = 1'b0;
        mOEN     = 1'b1;
        if (c_gnt) begin
            mADDR = cADDR;
            mDIN  = cDIN;
            mWE   = cWE & ~c_prot;
            mOEN  = cWE;
        end else if (l_gnt) begin
            mADDR = lADDR;
            mDIN  = lDIN;
            mWE   = lWE;
            mOEN  = lWE;
        end
        lGNT     = l_gnt;
        CPU_HOLD = creq & ~c_gnt;
        cRDY     = c_own_q;
        lACK     = l_own_q;
        cERR     = err_q;
        cDOUT    = (c_own_q && rd_q) ? mDOUT : cdout_q;
        lDOUT    = (l_own_q && rd_q) ? mDOUT : ldout_q;
    end

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            addr_q  <= '0;
            din_q   <= '0;
            c_own_q <= 1'b0;
            l_own_q <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            cdout_q <= '0;
            ldout_q <= '0;
        end else begin
            if (c_gnt || l_gnt) begin
                addr_q <= mADDR;
                din_q  <= mDIN;
            end
            c_own_q <= c_gnt;
            l_own_q <= l_gnt;
            rd_q    <= ~mOEN;
            err_q   <= c_gnt & c_prot;
            if (c_own_q && rd_q) cdout_q <= mDOUT;
            if (l_own_q && rd_q) ldout_q <= mDOUT;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a transaction-level fairness/memory model.
// Build with MEM_ARBITER_ROM_WP_EN defined to also exercise the ROM write protect.
module tb_mem_arbiter;
    localparam int          CW       = 4;
    localparam int          LB       = 16;
    localparam logic [15:0] ROM_BASE = 16'hF000;
`ifdef MEM_ARBITER_ROM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        CLK = 1'b0, R_N = 1'b0;
    logic        cREQ = 0, cWE = 0, lREQ = 0, lWE = 0;
    logic [15:0] cADDR = 0, lADDR = 0;
    logic [7:0]  cDIN = 0, lDIN = 0, mDOUT = 0;
    logic [7:0]  cDOUT, lDOUT, mDIN;
    logic [15:0] mADDR;
    logic        cRDY, CPU_HOLD, lACK, lGNT, mWE, mOEN, cERR;

    mem_arbiter dut (
        .CLK(CLK), .R_N(R_N),
        .cREQ(cREQ), .cWE(cWE), .cADDR(cADDR), .cDIN(cDIN), .cDOUT(cDOUT), .cRDY(cRDY), .CPU_HOLD(CPU_HOLD),
        .lREQ(lREQ), .lWE(lWE), .lADDR(lADDR), .lDIN(lDIN), .lDOUT(lDOUT), .lACK(lACK), .lGNT(lGNT),
        .mADDR(mADDR), .mDIN(mDIN), .mWE(mWE), .mOEN(mOEN), .mDOUT(mDOUT), .cERR(cERR)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [0:65535] = '{default: 8'h00};
    always @(posedge CLK) begin
        if (mWE) mem[mADDR] <= mDIN;
        mDOUT <= mem[mADDR];
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus intent, applied to the DUT at the next falling edge
    bit          s_creq, s_cwe, s_lreq, s_lwe;
    logic [15:0] s_caddr, s_laddr;
    logic [7:0]  s_cdin, s_ldin;

    // reference model
    logic [7:0]  ref_mem [0:65535];
    int          m_last, m_cs, m_ls;
    bit          m_lf;
    bit          p_c, p_l, p_crd, p_lrd, p_cerr;
    logic [7:0]  p_cd, p_ld, h_c, h_l, last_d;
    logic [15:0] last_a;
    bit          g_c, g_l, o_c, o_l;

    task automatic model_reset();
        m_last = 0; m_cs = 0; m_ls = 0; m_lf = 0;
        p_c = 0; p_l = 0; p_crd = 0; p_lrd = 0; p_cerr = 0;
        p_cd = 0; p_ld = 0; h_c = 0; h_l = 0; last_a = 0; last_d = 0;
    endtask

    task automatic step();
        bit          gc, gl, forced, prot, e_we, e_oen, e_hold;
        logic [15:0] ea;
        logic [7:0]  ed;
        @(negedge CLK);
        R_N = 1'b1;
        cREQ = s_creq; cWE = s_cwe; cADDR = s_caddr; cDIN = s_cdin;
        lREQ = s_lreq; lWE = s_lwe; lADDR = s_laddr; lDIN = s_ldin;
        #1;
        gc = 0; gl = 0; forced = 0;
        if (s_creq && s_lreq) begin
            if (m_last == 2) begin
                if (!m_lf && m_ls < LB) gl = 1; else gc = 1;
            end else if (m_cs >= CW) begin
                gl = 1; forced = 1;
            end else gc = 1;
        end else begin
            gc = s_creq; gl = s_lreq;
        end
        chk("cRDY", cRDY, p_c);
        chk("lACK", lACK, p_l);
        chk("cERR", cERR, p_cerr);
        chk("one_resp", cRDY & lACK, 0);
        if (p_c && p_crd) h_c = p_cd;
        if (p_l && p_lrd) h_l = p_ld;
        chk("cDOUT", cDOUT, h_c);
        chk("lDOUT", lDOUT, h_l);
        ea = gc ? s_caddr : (gl ? s_laddr : last_a);
        ed = gc ? s_cdin : (gl ? s_ldin : last_d);
        prot   = WP && gc && s_cwe && (s_caddr >= ROM_BASE);
        e_we   = (gc && s_cwe && !prot) || (gl && s_lwe);
        e_oen  = !((gc && !s_cwe) || (gl && !s_lwe));
        e_hold = s_creq && !gc;
        chk("lGNT", lGNT, gl);
        chk("CPU_HOLD", CPU_HOLD, e_hold);
        chk("mADDR", mADDR, ea);
        chk("mDIN", mDIN, ed);
        chk("mWE", mWE, e_we);
        chk("mOEN", mOEN, e_oen);
        o_c = cREQ & ~CPU_HOLD;
        o_l = lGNT;
        p_c = gc; p_l = gl; p_crd = gc && !s_cwe; p_lrd = gl && !s_lwe; p_cerr = prot;
        p_cd = ref_mem[s_caddr]; p_ld = ref_mem[s_laddr];
        if (gc && s_cwe && !prot) ref_mem[s_caddr] = s_cdin;
        if (gl && s_lwe) ref_mem[s_laddr] = s_ldin;
        if (gc || gl) begin last_a = ea; last_d = ed; end
        if (!s_lreq || gl) m_cs = 0;
        else if (gc && m_cs < CW) m_cs++;
        if (!s_creq || gc) begin m_ls = 0; m_lf = 0; end
        else if (gl) begin
            if (forced) m_lf = 1;
            if (m_ls < LB) m_ls++;
        end
        m_last = gc ? 1 : (gl ? 2 : 0);
        g_c = gc; g_l = gl;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        R_N = 1'b0;
        #1;
        chk("rst_mOEN", mOEN, 1);
        chk("rst_mWE", mWE, 0);
        chk("rst_cRDY", cRDY, 0);
        chk("rst_lACK", lACK, 0);
        chk("rst_lGNT", lGNT, 0);
        chk("rst_HOLD", CPU_HOLD, 0);
        @(posedge CLK);
        #1;
        chk("rst_cRDY_hold", cRDY, 0);
        model_reset();
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(2))
            0:       return 16'h0200 + 16'($urandom_range(15));
            1:       return 16'h8000 + 16'($urandom_range(15));
            default: return 16'hF000 + 16'($urandom_range(31));
        endcase
    endfunction

    initial begin
        logic [9:0] pat;
        int i, burst;
        bit cdone, cstarted;
        for (int a = 0; a < 65536; a++) ref_mem[a] = 8'h00;
        model_reset();
        s_creq = 0; s_cwe = 0; s_caddr = 0; s_cdin = 0;
        s_lreq = 0; s_lwe = 0; s_laddr = 0; s_ldin = 0;
        #2;
        chk("reset_mOEN", mOEN, 1);
        chk("reset_mWE", mWE, 0);
        chk("reset_mADDR", mADDR, 0);
        chk("reset_mDIN", mDIN, 0);
        chk("reset_cRDY", cRDY, 0);
        chk("reset_lACK", lACK, 0);
        chk("reset_cERR", cERR, 0);
        chk("reset_cDOUT", cDOUT, 0);
        chk("reset_lDOUT", lDOUT, 0);

        // preload 0xA9 at 0x0200 through the loader, then a CPU-only read
        s_lreq = 1; s_lwe = 1; s_laddr = 16'h0200; s_ldin = 8'hA9;
        step();
        s_lreq = 0;
        step();
        s_creq = 1; s_cwe = 0; s_caddr = 16'h0200;
        step();
        chk("cpu_rd_oen", mOEN, 0);
        chk("cpu_rd_addr", mADDR, 16'h0200);
        s_creq = 0;
        step();
        chk("cpu_rd_rdy", cRDY, 1);
        chk("cpu_rd_data", cDOUT, 8'hA9);
        step();

        // contention: both held, expect C,C,C,C,L,C,C,C,C,L
        pat = 10'b10_0001_0000;
        s_creq = 1; s_cwe = 0; s_caddr = rand_addr();
        s_lreq = 1; s_lwe = 0; s_laddr = rand_addr();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("contention_lgnt", lGNT, pat[k]);
            chk("contention_hold", CPU_HOLD, pat[k]);
            if (g_c) s_caddr = rand_addr();
            if (g_l) s_laddr = rand_addr();
        end
        s_creq = 0; s_lreq = 0;
        step(); step();

        // loader burst: 32 writes to 0x8000, CPU request arrives at write 3
        i = 0; burst = 0; cdone = 0; cstarted = 0;
        s_lreq = 1; s_lwe = 1; s_laddr = 16'h8000; s_ldin = 8'h00;
        for (int k = 0; k < 200 && !(i == 32 && cdone); k++) begin
            step();
            if (o_l && s_creq) burst++;
            if (g_c) begin s_creq = 0; cdone = 1; end
            if (g_l) begin
                i++;
                if (i < 32) begin s_laddr = 16'h8000 + 16'(i); s_ldin = 8'(i); end
                else s_lreq = 0;
            end
            if (i == 3 && !cstarted) begin
                cstarted = 1; s_creq = 1; s_cwe = 0; s_caddr = 16'h8000;
            end
        end
        if (!(i == 32 && cdone)) chk("burst_timeout", cdone, 1);
        chk("ldr_burst_len", burst, 16);
        step(); step();
        for (int k = 0; k < 32; k++) chk("burst_mem", mem[16'h8000 + 16'(k)], k);

        // loader alone for 3 grants, then CPU joins: loader keeps the bus
        s_lreq = 1; s_lwe = 0; s_laddr = rand_addr();
        repeat (3) begin step(); s_laddr = rand_addr(); end
        s_creq = 1; s_cwe = 0; s_caddr = rand_addr();
        step();
        chk("simul_ldr_prio", lGNT, 1);
        repeat (20) begin
            step();
            if (g_c) s_caddr = rand_addr();
            if (g_l) s_laddr = rand_addr();
        end
        s_creq = 0; s_lreq = 0;
        step(); step();

`ifdef MEM_ARBITER_ROM_WP_EN
        s_creq = 1; s_cwe = 1; s_caddr = 16'hF010; s_cdin = 8'h55;
        step();
        chk("wp_mwe", mWE, 0);
        s_creq = 0;
        step();
        chk("wp_cerr", cERR, 1);
        chk("wp_crdy", cRDY, 1);
        s_lreq = 1; s_lwe = 1; s_laddr = 16'hF010; s_ldin = 8'h55;
        step();
        s_lwe = 0;
        step();
        s_lreq = 0;
        step();
        chk("wp_ldr_rd", lDOUT, 8'h55);
        step();
`endif

        // randomized traffic with a mid-stream reset
        for (int k = 0; k < 1500; k++) begin
            if (k == 700) apply_reset();
            step();
            if (g_c || !s_creq) begin
                s_creq = ($urandom_range(99) < 60);
                s_cwe = $urandom_range(1); s_caddr = rand_addr(); s_cdin = 8'($urandom);
            end else if ($urandom_range(99) < 10) s_caddr = rand_addr();
            if (g_l || !s_lreq) begin
                s_lreq = ($urandom_range(99) < 50);
                s_lwe = $urandom_range(1); s_laddr = rand_addr(); s_ldin = 8'($urandom);
            end else if ($urandom_range(99) < 10) s_laddr = rand_addr();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
